req_idx_encoder: RTL and testbench

- Reverse of the 5-to-32 one-hot enable decoder used in the processor and DMA datapath.
- Collects up to 32 request lines (DMA channels and peripheral interrupt sources) into a sticky pending register.
- Selects one pending request by round-robin priority and offers its 5-bit index to the consumer through a valid/ack handshake.
- Clears the accepted request and moves the priority pointer past it.

---
 rtl/req_idx_if.sv | 33 +++
 rtl/req_idx_encoder.sv | 134 +++++++++++++
 tb/tb_req_idx_encoder.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/req_idx_if.sv
// Request/index handshake bundle for req_idx_encoder.
// slave  : the encoder side (takes requests and acks, drives index/status).
// master : the requester/consumer side.
interface req_idx_if #(
  parameter int IDX_W = 5
);
  localparam int NREQ = 2 ** IDX_W;

  logic [NREQ-1:0]  req_in;
  logic             idx_ack;
  logic [IDX_W-1:0] idx_out;
  logic             idx_valid;
  logic [NREQ-1:0]  pend_out;
  logic             none_pending;

  modport slave (
    input  req_in,
    input  idx_ack,
    output idx_out,
    output idx_valid,
    output pend_out,
    output none_pending
  );

  modport master (
    output req_in,
    output idx_ack,
    input  idx_out,
    input  idx_valid,
    input  pend_out,
    input  none_pending
  );
endinterface

// File: rtl/req_idx_encoder.sv
// req_idx_encoder: collects request lines into a sticky pending register and
// offers one pending index at a time through a valid/ack handshake.
//
// Build option: define REQ_IDX_ROUND_ROBIN_EN for round-robin selection that
// starts just past the last accepted index. Without it the lowest pending
// index always wins and no last-grant pointer exists.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no offer outstanding; searching pending for a winner
// OFFER | idx_out holds a pending index, waiting for idx_ack
module req_idx_encoder #(
  parameter int IDX_W   = 5,
  parameter int PTR_RST = 31
) (
  input  logic   clk,
  input  logic   rst,
  req_idx_if.slave bus
);
  localparam int NREQ = 2 ** IDX_W;

  // Reject a reset pointer that cannot be represented as an index.
  if (PTR_RST < 0 || PTR_RST >= NREQ) begin : g_bad_ptr_rst
    $error("req_idx_encoder: PTR_RST out of range");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             none_pend_q, none_pend_d;
  logic [NREQ-1:0]  clr_mask;
  logic             accept;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

`ifdef REQ_IDX_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
`endif

  assign accept = (state_q == OFFER) && bus.idx_ack;

  // Winner search over the registered pending vector.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef REQ_IDX_ROUND_ROBIN_EN
      // Start one past the last grant; the IDX_W-bit add wraps modulo NREQ.
      cand = last_ptr_q + IDX_W'(i + 1);
`else
      cand = IDX_W'(i);
`endif
      if (!win_found && pend_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pending update: accepted bit cleared, new requests set (set wins).
  always_comb begin
    clr_mask    = '0;
    if (accept) begin
      clr_mask = NREQ'(1) << idx_q;
    end
    pend_d      = (pend_q & ~clr_mask) | bus.req_in;
    none_pend_d = (pend_d == '0);
  end

  // Handshake FSM: next state, offered index and last-grant pointer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
`ifdef REQ_IDX_ROUND_ROBIN_EN
    last_ptr_d = last_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          idx_d   = win_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (bus.idx_ack) begin
`ifdef REQ_IDX_ROUND_ROBIN_EN
          last_ptr_d = idx_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      idx_q       <= '0;
      none_pend_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      idx_q       <= idx_d;
      none_pend_q <= none_pend_d;
    end
  end

`ifdef REQ_IDX_ROUND_ROBIN_EN
  // Last-grant pointer; the reset value makes the first search begin at PTR_RST+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ptr_q <= IDX_W'(PTR_RST);
    end else begin
      last_ptr_q <= last_ptr_d;
    end
  end
`endif

  assign bus.idx_out      = idx_q;
  assign bus.idx_valid    = (state_q == OFFER);
  assign bus.pend_out     = pend_q;
  assign bus.none_pending = none_pend_q;

endmodule

// File: tb/tb_req_idx_encoder.sv
// Directed bench for req_idx_encoder; expectations follow the selection mode
// chosen by REQ_IDX_ROUND_ROBIN_EN.
module tb_req_idx_encoder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  req_idx_if #(.IDX_W(5)) bus ();

  req_idx_encoder #(.IDX_W(5), .PTR_RST(31)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_req(input logic [31:0] r);
    bus.req_in = r;
    tick();
    bus.req_in = '0;
  endtask

  task automatic expect_offer(input string tag, input logic [31:0] exp_idx);
    int n;
    n = 0;
    while (bus.idx_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(bus.idx_valid), 32'd1);
    check({tag, "_idx"}, 32'(bus.idx_out), exp_idx);
  endtask

  task automatic accept();
    bus.idx_ack = 1'b1;
    tick();
    bus.idx_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.req_in  = '0;
    bus.idx_ack = 1'b0;
    #12;
    check("rst_valid", 32'(bus.idx_valid), 32'd0);
    check("rst_pend", bus.pend_out, 32'h0);
    check("rst_none", 32'(bus.none_pending), 32'd1);
    check("rst_idx", 32'(bus.idx_out), 32'd0);
    tick();
    rst = 1'b0;

    // single request, exact latency
    pulse_req(32'h0000_0010);
    check("t1_pend", bus.pend_out, 32'h10);
    check("t1_none", 32'(bus.none_pending), 32'd0);
    check("t1_valid_early", 32'(bus.idx_valid), 32'd0);
    tick();
    check("t1_valid", 32'(bus.idx_valid), 32'd1);
    check("t1_idx", 32'(bus.idx_out), 32'd4);
    tick();
    tick();
    check("t1_hold", 32'(bus.idx_valid), 32'd1);
    accept();
    check("t1_ack_valid", 32'(bus.idx_valid), 32'd0);
    check("t1_ack_pend", bus.pend_out, 32'h0);
    check("t1_ack_none", 32'(bus.none_pending), 32'd1);

    // fairness from reset
    do_reset();
    pulse_req(32'h8000_0003);
    tick();
    check("t2_lat_valid", 32'(bus.idx_valid), 32'd1);
    check("t2_first", 32'(bus.idx_out), 32'd0);
    accept();
    expect_offer("t2_second", 32'd1);
    accept();
    expect_offer("t2_third", 32'd31);
    accept();
    pulse_req(32'h8000_0001);
    expect_offer("t2_re0", 32'd0);
    accept();
    expect_offer("t2_re31", 32'd31);
    accept();

    // wrap-around past last grant 30
    pulse_req(32'h4000_0000);
    expect_offer("t3_30", 32'd30);
    accept();
    pulse_req(32'h8000_0004);
`ifdef REQ_IDX_ROUND_ROBIN_EN
    expect_offer("t3_a", 32'd31);
    accept();
    expect_offer("t3_b", 32'd2);
`else
    expect_offer("t3_a", 32'd2);
    accept();
    expect_offer("t3_b", 32'd31);
`endif
    accept();

    // set beats clear on index 7
    pulse_req(32'h0000_0080);
    expect_offer("t4_7", 32'd7);
    pulse_req(32'h0000_0208);
    check("t4_stable", 32'(bus.idx_out), 32'd7);
    bus.req_in  = 32'h0000_0080;
    bus.idx_ack = 1'b1;
    tick();
    bus.req_in  = '0;
    bus.idx_ack = 1'b0;
    check("t4_pend", bus.pend_out, 32'h288);
    check("t4_valid", 32'(bus.idx_valid), 32'd0);
`ifdef REQ_IDX_ROUND_ROBIN_EN
    expect_offer("t4_a", 32'd9);
    accept();
    expect_offer("t4_b", 32'd3);
    accept();
    expect_offer("t4_c", 32'd7);
`else
    expect_offer("t4_a", 32'd3);
    accept();
    expect_offer("t4_b", 32'd7);
    accept();
    expect_offer("t4_c", 32'd9);
`endif
    accept();

    // offer held while new requests arrive
    pulse_req(32'h0000_0020);
    expect_offer("t5_5", 32'd5);
    pulse_req(32'h0000_0004);
    check("t5_idx", 32'(bus.idx_out), 32'd5);
    check("t5_valid", 32'(bus.idx_valid), 32'd1);
    check("t5_pend", bus.pend_out, 32'h24);
    tick();
    check("t5_idx2", 32'(bus.idx_out), 32'd5);
    accept();
    expect_offer("t5_2", 32'd2);
    accept();
    tick();
    check("t5_empty", bus.pend_out, 32'h0);

    // stray ack while idle
    bus.idx_ack = 1'b1;
    tick();
    tick();
    bus.idx_ack = 1'b0;
    check("t6_valid", 32'(bus.idx_valid), 32'd0);
    check("t6_pend", bus.pend_out, 32'h0);
    check("t6_none", 32'(bus.none_pending), 32'd1);

    // asynchronous reset during an offer
    pulse_req(32'h0000_00F0);
    expect_offer("t7_4", 32'd4);
    check("t7_pend", bus.pend_out, 32'hF0);
    #3;
    rst = 1'b1;
    #1;
    check("t7_rst_valid", 32'(bus.idx_valid), 32'd0);
    check("t7_rst_pend", bus.pend_out, 32'h0);
    check("t7_rst_none", 32'(bus.none_pending), 32'd1);
    tick();
    rst = 1'b0;
    pulse_req(32'h8000_0000);
    check("t7_pend31", bus.pend_out, 32'h8000_0000);
    tick();
    check("t7_valid31", 32'(bus.idx_valid), 32'd1);
    check("t7_idx31", 32'(bus.idx_out), 32'd31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
